// File: rtl/arm_mem_pkg.sv
// Shared types and address constants for the data-memory responder.
// Word-addressed store behind a byte-addressed port; ADDR_LSB strips the byte offset.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter: loads a start value, decrements to zero, then holds.
// The zero flag is registered, so it asserts one cycle after the count reaches zero.
module mem_wait_counter
  import arm_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load) begin
      cnt_d  = load_val;
      zero_d = 1'b0;
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
      zero_d = (cnt_q == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one request at a time, response WAIT_CYCLES+1 edges after accept.
// Single outstanding request; rsp_* held stable while rsp_ready is low, req_ready low until back in IDLE.
module data_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e state_q, state_d;

  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        cnt_load;
  logic        cnt_zero;

  logic [31:0] mem_q [DEPTH];

  // With zero wait states the RESP-entry edge is the accept edge, so the
  // access must use the live request rather than the latched copy.
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          enter_resp;
  logic          mem_we;

  mem_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .zero     (cnt_zero)
  );

  always_comb begin
    acc_write = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
  end

  assign acc_idx = acc_addr[ADDR_LSB +: AW];
  assign acc_err = (acc_addr[ADDR_LSB-1:0] != '0) || (|acc_addr[31:ADDR_LSB+AW]);

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_load   = 1'b0;
    enter_resp = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
            state_d    = ST_RESP;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          enter_resp = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = '0;
      if (!acc_err) begin
        if (acc_write) begin
          mem_we = 1'b1;
        end else begin
          rsp_rdata_d = mem_q[acc_idx];
        end
      end
    end
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array reference model.
// Checks latency, data, error flag, backpressure stability and mid-transaction reset.
module tb_data_mem_responder;

  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 2;
  localparam int MAX_EDGES   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   {31'd0, rsp_err},   32'd0);
  endtask

  // One full request/response; hold = cycles rsp_ready stays low in RESP.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          edges;
    logic [31:0] word;
    word    = addr / 4;
    exp_err = (addr % 4 != 0) || (word >= DEPTH);
    exp_rd  = (!wr && !exp_err) ? model_mem[word] : 32'd0;

    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    edges = 0;
    do begin
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      req_valid = 1'($urandom);
      @(posedge clk);
      #1;
      edges++;
    end while (!rsp_valid && edges < MAX_EDGES);
    check("rsp_latency", edges, WAIT_CYCLES + 1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_addr  = $urandom;
      @(posedge clk);
      #1;
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, exp_rd);
      check("hold_rsp_err",   {31'd0, rsp_err}, {31'd0, exp_err});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end

    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);

    if (wr && !exp_err) model_mem[word] = wd;
  endtask

  task automatic scan_all();
    for (int i = 0; i < DEPTH; i++) do_txn(1'b0, 32'(i * 4), 32'd0, 0);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("after_reset");

    do_txn(1'b0, 32'h10, 32'd0, 0);
    do_txn(1'b1, 32'h20, 32'hDEADBEEF, 0);
    do_txn(1'b0, 32'h20, 32'd0, 0);
    do_txn(1'b1, 32'h22, 32'h12345678, 0);
    do_txn(1'b0, 32'h20, 32'd0, 0);
    do_txn(1'b0, 32'h100, 32'd0, 0);
    do_txn(1'b1, 32'h100, 32'hCAFEF00D, 0);
    do_txn(1'b1, 32'hFFFF_FFFC, 32'h0BADF00D, 0);
    scan_all();
    do_txn(1'b0, 32'h20, 32'd0, 5);

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, 15)) * 4;
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (sel == 8) a = (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
      else               a = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFC);
      do_txn(1'($urandom), a, $urandom, $urandom_range(0, 3));
    end
    scan_all();

    do_txn(1'b1, 32'h04, 32'h11112222, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h04;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_wait_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("after_mid_reset");
    do_txn(1'b0, 32'h04, 32'd0, 0);
    do_txn(1'b0, 32'h20, 32'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
